imem_boot_ctrl: RTL

Boot-load controller for the single-cycle core's instruction memory. It holds the CPU in reset and accepts a stream of 32-bit instruction words over a valid/ready handshake. Each word is written to consecutive instruction-memory word addresses starting at 0. Once the final write has committed, it releases the CPU and reports a word count and an additive checksum for host-side verification.

---
 rtl/imem_boot_ctrl_pkg.sv | 13 +
 rtl/imem_boot_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl_pkg.sv
// Shared types and widths for the instruction-memory boot-load controller.
package imem_boot_ctrl_pkg;

   localparam int INSTR_LEN = 32;

   typedef enum logic [1:0] {
      BOOT_HOLD  = 2'd0,
      BOOT_LOAD  = 2'd1,
      BOOT_DRAIN = 2'd2,
      BOOT_RUN   = 2'd3
   } boot_state_e;

endpackage

// File: rtl/imem_boot_ctrl.sv
// Boot-load controller: streams instruction words into IMEM from address 0,
// holding the CPU in reset until the final registered write has committed.
module imem_boot_ctrl
   import imem_boot_ctrl_pkg::*;
#(
   parameter int IMEM_SIZE = 1024,
   parameter int AW        = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_start,
   input  logic [AW:0]          load_len,
   input  logic                 s_valid,
   input  logic [INSTR_LEN-1:0] s_data,
   output logic                 s_ready,
   output logic                 mem_we,
   output logic [AW-1:0]        mem_waddr,
   output logic [INSTR_LEN-1:0] mem_wdata,
   output logic                 cpu_hold,
   output logic                 load_done,
   output logic [AW:0]          words_loaded,
   output logic [31:0]          checksum,
   output logic                 err,
   output logic [1:0]           boot_state
);

   localparam logic [AW:0] MAX_LEN = (AW+1)'(IMEM_SIZE);
   localparam logic [AW:0] ONE     = (AW+1)'(1);

   boot_state_e          state_q, state_d;
   logic [AW:0]          len_q, len_d;
   logic [AW:0]          words_q, words_d;
   logic [31:0]          csum_q, csum_d;
   logic                 we_q, we_d;
   logic [AW-1:0]        waddr_q, waddr_d;
   logic [INSTR_LEN-1:0] wdata_q, wdata_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [AW:0]          words_inc;

   assign words_inc = words_q + ONE;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      words_d = words_q;
      csum_d  = csum_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      done_d  = done_q;
      err_d   = err_q;
      case (state_q)
         BOOT_HOLD, BOOT_RUN: begin
            if (load_start) begin
               words_d = '0;
               csum_d  = '0;
               if (load_len == '0) begin
                  state_d = BOOT_RUN;
                  done_d  = 1'b1;
               end else begin
                  state_d = BOOT_LOAD;
                  done_d  = 1'b0;
                  // Clamping keeps the write address from ever wrapping.
                  if (load_len > MAX_LEN) begin
                     len_d = MAX_LEN;
                     err_d = 1'b1;
                  end else begin
                     len_d = load_len;
                  end
               end
            end
         end
         BOOT_LOAD: begin
            if (s_valid) begin
               we_d    = 1'b1;
               waddr_d = words_q[AW-1:0];
               wdata_d = s_data;
               csum_d  = csum_q + s_data;
               words_d = words_inc;
               if (words_inc == len_q) state_d = BOOT_DRAIN;
            end
         end
         BOOT_DRAIN: begin
            // The final write is on the port this cycle; release only after it commits.
            state_d = BOOT_RUN;
            done_d  = 1'b1;
         end
         default: state_d = BOOT_HOLD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BOOT_HOLD;
         len_q   <= '0;
         words_q <= '0;
         csum_q  <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         words_q <= words_d;
         csum_q  <= csum_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign s_ready      = (state_q == BOOT_LOAD);
   assign cpu_hold     = (state_q != BOOT_RUN);
   assign mem_we       = we_q;
   assign mem_waddr    = waddr_q;
   assign mem_wdata    = wdata_q;
   assign load_done    = done_q;
   assign words_loaded = words_q;
   assign checksum     = csum_q;
   assign err          = err_q;
   assign boot_state   = state_q;

endmodule
